// File: rtl/aes_pkg.sv
// Shared AES definitions for the key schedule and the round datapath.
//   word_t / block_t : 32-bit word and 128-bit block types
//   NR               : rounds after round 0 (AES-128 only)
//   RCON             : round constants, indexed by the round being left (0..9)
//   state_e          : key-expansion FSM states
package aes_pkg;

  typedef logic [31:0]  word_t;
  typedef logic [127:0] block_t;

  localparam int NR = 10;

  localparam logic [7:0] RCON [0:NR-1] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
    8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } state_e;

endpackage

// File: rtl/aes_sbox.sv
// FIPS-197 forward S-box, purely combinational table lookup.
// Shared between the key schedule (SubWord) and the subBytes stage.
//   in_byte  : input byte
//   out_byte : substituted byte
module aes_sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  // Listed in natural order (entry 0x00 first). Because the leftmost byte of
  // a [255:0] packed array is index 255, entry x lives at index 255-x == ~x.
  localparam logic [255:0][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign out_byte = SBOX[~in_byte];

endmodule

// File: rtl/aes_key_expand.sv
// Iterative AES-128 key schedule feeding addRoundKey.
// Loads the cipher key on start, then presents round keys 0..NR one per
// rk_valid/rk_ready handshake, deriving each next key combinationally from
// the current one (4 shared S-boxes + XOR chain). Pulses done for one cycle
// after round NR is accepted.
//   clk, reset_n     : clock, synchronous active-low reset
//   key_in, start    : cipher key and expansion request (sampled in IDLE)
//   rk_ready         : consumer accepts current round key
//   rk_valid, rk     : current round key and its qualifier
//   round            : index of rk (0..NR)
//   busy, done       : expansion in flight / one-cycle completion pulse
// Optional build macro AES_RK_STORE_EN adds an 11-entry round-key store with
//   rd_idx (in) / rd_key (out) for decrypt-direction reuse.
module aes_key_expand
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         reset_n,
  input  logic [127:0] key_in,
  input  logic         start,
  input  logic         rk_ready,
  output logic         rk_valid,
  output logic [127:0] rk,
  output logic [3:0]   round,
  output logic         busy,
  output logic         done
`ifdef AES_RK_STORE_EN
  ,
  input  logic [3:0]   rd_idx,
  output logic [127:0] rd_key
`endif
);

  localparam logic [3:0] LAST_RND = 4'(NR);

  state_e     state_q,    state_d;
  block_t     rk_q,       rk_d;
  logic [3:0] round_q,    round_d;
  logic       rk_valid_q, rk_valid_d;
  logic       busy_q,     busy_d;
  logic       done_q,     done_d;

  logic       accept;
  assign accept = (state_q == ST_RUN) && rk_valid_q && rk_ready;

  // ---------------------------------------------------------------------
  // next(rk): SubWord(RotWord(w3)) ^ rcon, then the w0..w3 XOR chain
  // ---------------------------------------------------------------------
  word_t            w0, w1, w2, w3, rot_w, temp_w;
  word_t            n0, n1, n2, n3;
  logic [3:0][7:0]  sb_in, sb_out;
  logic [7:0]       rcon_b;
  block_t           rk_next;

  assign {w0, w1, w2, w3} = rk_q;
  assign rot_w = {w3[23:0], w3[31:24]};
  assign sb_in = rot_w;

  for (genvar g = 0; g < 4; g++) begin : g_sub
    aes_sbox u_sbox (
      .in_byte  (sb_in[g]),
      .out_byte (sb_out[g])
    );
  end

  // Round NR never advances, so its rcon is don't-care; return 0 there.
  assign rcon_b  = (round_q < LAST_RND) ? RCON[round_q] : 8'h00;
  assign temp_w  = word_t'(sb_out) ^ {rcon_b, 24'h0};
  assign n0      = w0 ^ temp_w;
  assign n1      = w1 ^ n0;
  assign n2      = w2 ^ n1;
  assign n3      = w3 ^ n2;
  assign rk_next = {n0, n1, n2, n3};

  // ---------------------------------------------------------------------
  // Control
  // ---------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    rk_d       = rk_q;
    round_d    = round_q;
    rk_valid_d = rk_valid_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_RUN;
          rk_d       = key_in;
          round_d    = 4'd0;
          rk_valid_d = 1'b1;
          busy_d     = 1'b1;
        end
      end
      ST_RUN: begin
        if (accept) begin
          if (round_q == LAST_RND) begin
            // rk/round deliberately hold their final values
            state_d    = ST_IDLE;
            rk_valid_d = 1'b0;
            busy_d     = 1'b0;
            done_d     = 1'b1;
          end else begin
            rk_d    = rk_next;
            round_d = round_q + 4'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      rk_q       <= '0;
      round_q    <= '0;
      rk_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rk_q       <= rk_d;
      round_q    <= round_d;
      rk_valid_q <= rk_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign rk_valid = rk_valid_q;
  assign rk       = rk_q;
  assign round    = round_q;
  assign busy     = busy_q;
  assign done     = done_q;

`ifdef AES_RK_STORE_EN
  // ---------------------------------------------------------------------
  // Round-key store: written on every accept, survives done
  // ---------------------------------------------------------------------
  block_t store_q [0:NR];
  block_t store_d [0:NR];

  always_comb begin
    store_d = store_q;
    if (accept) store_d[round_q] = rk_q;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i <= NR; i++) store_q[i] <= '0;
    end else begin
      store_q <= store_d;
    end
  end

  assign rd_key = (rd_idx <= LAST_RND) ? store_q[rd_idx] : '0;
`endif

endmodule

// File: doc/aes_key_expand.md
Name: aes_key_expand

Overview:
- Iterative AES-128 key schedule. Accepts a 128-bit cipher key and emits round keys 0..10, one per accepted handshake.
- Sits directly upstream of addRoundKey and supplies its roundkey operand each round.
- Round keys are generated on the fly with four shared S-box lookups. No 11-entry key store is needed in the base configuration.

Parameters:
- NR, 10, number of rounds after round 0. Only 10 (AES-128) is legal; the Rcon table covers 10 entries.

Ports:
- clk  input  1  system clock, rising edge
- reset_n  input  1  synchronous, active-low reset
- key_in  input  128  cipher key; byte 0 = key_in[127:120]; w0 = key_in[127:96]
- start  input  1  request expansion; sampled only in IDLE
- rk_ready  input  1  consumer accepts the current round key
- rk_valid  output  1  rk/round are valid
- rk  output  128  current round key, same byte order as key_in
- round  output  4  index of rk, 0..10
- busy  output  1  high from the start accept through the final accept
- done  output  1  one-cycle pulse after round 10 is accepted

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-low on reset_n.
- Reset values: all outputs 0; FSM in IDLE. Reset mid-expansion aborts immediately; no partial done.
- FSM states: IDLE, RUN.
- IDLE -> RUN:
  - Trigger: start=1 at an edge.
  - Next cycle: rk=key_in as sampled at that edge, round=0, rk_valid=1, busy=1.
- RUN, accept (rk_valid && rk_ready at an edge):
  - If round<10: rk <= next(rk), round <= round+1, rk_valid stays 1.
  - If round==10: go IDLE; rk_valid=0, busy=0, done=1 for exactly one cycle; rk and round hold their last values.
- RUN, no accept: rk, round and rk_valid hold stable. This is a backpressure stall of any length.
- start while busy: ignored, including start coincident with the final accept. A new start is honoured from the done cycle onward, since the FSM is IDLE then.
- key_in changes after the start sample: no effect on the running expansion.
- next(rk):
  - w0..w3 = rk[127:96], rk[95:64], rk[63:32], rk[31:0].
  - temp = SubWord({w3[23:0], w3[31:24]}) ^ {rcon[round], 24'h0}.
  - w0' = w0^temp; w1' = w1^w0'; w2' = w2^w1'; w3' = w3^w2'.
  - rcon[0..9] = 01,02,04,08,10,20,40,80,1B,36; rcon is indexed by the current round (0..9).
- Throughput: with rk_ready tied to 1, round keys 0..10 appear on 11 consecutive cycles after the start edge, and done asserts on the 12th cycle.
- next(rk) is purely combinational from the rk register: 4 S-boxes plus an XOR chain in one cycle; no pipelining.

Optional Feature:
- Macro: AES_RK_STORE_EN.
- Defined:
  - Each accepted round key is also written into an internal 11x128 register file.
  - Extra ports: rd_idx input 4 and rd_key output 128. rd_key = store[rd_idx] combinationally; rd_idx>10 returns 0.
  - Store contents persist after done, for decrypt-direction reuse. Reset clears the store to 0.
  - A new start overwrites entries as they are accepted.
- Undefined: no store and no extra ports; behaviour is otherwise identical.

Decomposition:
- aes_pkg:
  - typedefs word_t (logic [31:0]) and block_t (logic [127:0]).
  - localparam NR=10.
  - RCON constant array [0:9] of 8-bit values.
  - FSM state enum.
- Sub-module aes_sbox: combinational 8-bit in / 8-bit out FIPS-197 S-box table, instantiated 4 times for SubWord. It is shared with the subBytes stage.

Test Plan:
- FIPS-197 key, rk_ready=1:
  - Stimulus: reset_n low 2 cycles, key_in=2b7e151628aed2a6abf7158809cf4f3c, start pulse.
  - Round 0 = key_in; round 1 = a0fafe1788542cb123a339392a6c7605; round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
  - done pulses once, on cycle 12 after the start edge.
- Backpressure: same key, rk_ready=0 for 5 cycles while round=1. rk must stay a0fafe17... and round=1 throughout; with rk_ready=1 from then on, round 10 is still correct.
- Start while busy: start asserted with key_in=000...0 during round 4. It is ignored and the output sequence matches the FIPS vector exactly.
- Reset mid-run: reset_n=0 at round 6 for 1 cycle. All outputs read 0 the next cycle and no done pulse occurs. A subsequent start with key_in=000102030405060708090a0b0c0d0e0f yields round 10 = 13111d7fe3944a17f307a78b4d2b30c5.
- Back-to-back: start held at 1 continuously. A second expansion begins the cycle after done, with round=0 and rk=the current key_in.
- With AES_RK_STORE_EN: after the FIPS run, rd_idx=1 returns a0fafe17...; rd_idx=10 returns d014f9a8...; rd_idx=12 returns 0.
